// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: state encodings and default width.
package serial_add_pkg;

   localparam int WIDTH_DEF = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADD  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      ADD  = ST_ADD,
      DONE = ST_DONE
   } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the serial controller time-shares a single instance.
module full_adder (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = x ^ y ^ cin;
   assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB first through one full_adder cell,
// holding the running carry in a flop and publishing a registered result with a done pulse.
//
// state | meaning
// IDLE  | waiting for start; operands loaded on the accepting edge
// ADD   | one bit step per edge, WIDTH steps total
// DONE  | result valid, done high for one cycle
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr;
   logic [CW-1:0]    cnt;
   logic             carry_q;
   logic             fa_s, fa_c;
   logic             last_bit;

   full_adder u_fa (
      .x    (a_sr[0]),
      .y    (b_sr[0]),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (fa_c)
   );

   assign last_bit = (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ADD;
         ADD:     if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr      <= '0;
         b_sr      <= '0;
         res_sr    <= '0;
         cnt       <= '0;
         carry_q   <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr    <= a;
                  b_sr    <= b;
                  carry_q <= carry_in;
                  cnt     <= '0;
                  res_sr  <= '0;
               end
            end
            ADD: begin
               a_sr    <= a_sr >> 1;
               b_sr    <= b_sr >> 1;
               res_sr  <= {fa_s, res_sr[WIDTH-1:1]};
               carry_q <= fa_c;
               // counter saturates at the last bit rather than wrapping
               if (!last_bit) cnt <= cnt + 1'b1;
               if (last_bit) begin
                  sum       <= {fa_s, res_sr[WIDTH-1:1]};
                  carry_out <= fa_c;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == ADD);
   assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=2 against plain-arithmetic expectations.
module tb_serial_add_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8, cin8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;
   logic       start2, cin2, busy2, done2, cout2;
   logic [1:0] a2, b2, sum2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .carry_in(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .carry_out(cout8)
   );

   serial_add_ctrl #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .carry_in(cin2),
      .busy(busy2), .done(done2), .sum(sum2), .carry_out(cout2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // After the accepting edge: counts edges until done, busy cycles, and busy/done overlap.
   task automatic wait_done8(output int cyc, output int bcnt, output int ovl);
      cyc = 0; bcnt = 0; ovl = 0;
      while (!done8 && cyc < 40) begin
         if (busy8) bcnt++;
         step();
         cyc++;
      end
      if (busy8 && done8) ovl++;
   endtask

   task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic tc);
      int cyc, bcnt, ovl;
      logic [8:0] exp;
      exp = {1'b0, ta} + {1'b0, tb_} + {8'd0, tc};
      a8 = ta; b8 = tb_; cin8 = tc; start8 = 1'b1;
      step();
      start8 = 1'b0;
      a8 = $urandom; b8 = $urandom; cin8 = $urandom;
      wait_done8(cyc, bcnt, ovl);
      chk({tag, "_latency"}, cyc, 8);
      chk({tag, "_busy_cycles"}, bcnt, 8);
      chk({tag, "_overlap"}, ovl, 0);
      chk({tag, "_result"}, {cout8, sum8}, exp);
      step();
      chk({tag, "_done_pulse"}, done8, 0);
   endtask

   task automatic run2(input logic [1:0] ta, input logic [1:0] tb_, input logic tc);
      int cyc;
      logic [2:0] exp;
      exp = {1'b0, ta} + {1'b0, tb_} + {2'd0, tc};
      a2 = ta; b2 = tb_; cin2 = tc; start2 = 1'b1;
      step();
      start2 = 1'b0;
      cyc = 0;
      while (!done2 && cyc < 20) begin
         step();
         cyc++;
      end
      chk("w2_latency", cyc, 2);
      chk("w2_result", {cout2, sum2}, exp);
      step();
   endtask

   initial begin
      int cyc, bcnt, ovl, n;
      rst = 1'b1;
      start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
      start2 = 0; a2 = 0; b2 = 0; cin2 = 0;
      #1;
      chk("rst_busy", busy8, 0);
      chk("rst_done", done8, 0);
      chk("rst_sum", sum8, 0);
      chk("rst_cout", cout8, 0);
      step(); step();
      rst = 1'b0;
      step();

      run8("t0f_01", 8'h0F, 8'h01, 1'b0);
      run8("tff_01", 8'hFF, 8'h01, 1'b0);
      run8("tff_ff", 8'hFF, 8'hFF, 1'b1);

      // start pulses during ADD (cycle 3) and DONE must be ignored
      a8 = 8'h12; b8 = 8'h34; cin8 = 0; start8 = 1;
      step();
      start8 = 0;
      step(); step(); step();
      a8 = 8'hAA; b8 = 8'h55; start8 = 1;
      step();
      start8 = 0;
      cyc = 4;
      while (!done8 && cyc < 40) begin step(); cyc++; end
      chk("ign_latency", cyc, 8);
      a8 = 8'hAA; b8 = 8'h55; start8 = 1;
      step();
      start8 = 0;
      chk("ign_result", {cout8, sum8}, 9'h046);
      n = 0;
      for (int i = 0; i < 12; i++) begin
         if (done8 || busy8) n++;
         step();
      end
      chk("ign_no_restart", n, 0);

      // asynchronous reset in the middle of an add
      a8 = 8'hF0; b8 = 8'h0F; cin8 = 0; start8 = 1;
      step();
      start8 = 0;
      step(); step(); step(); step();
      chk("mid_busy_before_rst", busy8, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", busy8, 0);
      chk("arst_done", done8, 0);
      chk("arst_sum", sum8, 0);
      chk("arst_cout", cout8, 0);
      step();
      rst = 1'b0;
      step();
      chk("arst_idle", {busy8, done8}, 0);
      run8("t01_02", 8'h01, 8'h02, 1'b0);

      // continuous start: accepts at E0 and E10
      a8 = 8'h80; b8 = 8'h80; cin8 = 0; start8 = 1;
      step();
      wait_done8(cyc, bcnt, ovl);
      chk("hold_first_latency", cyc, 8);
      chk("hold_first_result", {cout8, sum8}, 9'h100);
      step();
      wait_done8(cyc, bcnt, ovl);
      chk("hold_second_gap", cyc, 9);
      chk("hold_second_busy", bcnt, 8);
      chk("hold_second_result", {cout8, sum8}, 9'h100);
      start8 = 0;
      step(); step();

      for (int i = 0; i < 20; i++)
         run8("rand", 8'($urandom), 8'($urandom), 1'($urandom));

      for (int v = 0; v < 32; v++)
         run2(2'(v >> 3), 2'(v >> 1), 1'(v));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
